ycbcr_frame_ctrl: RTL and testbench
===================================

Name: ycbcr_frame_ctrl

Overview:
- Sequences one frame through the 32-bit Y/Cb/Cr pixel buffer memory.
- Clears the memory address counters, then accepts a frame of frame_len pixels from the colour-conversion stage (fill).
- Then replays those pixels in order to the downstream compression stage (drain) via valid/ready.
- Owns all buffer control pins (enable, en_write, en_read); the pixel data buses connect directly between stages and memory.

Parameters:
- CNT_W, 21, width of pixel counters and frame_len (holds values up to DEPTH).
- DEPTH, 1048576, buffer capacity in pixels; upper bound for frame_len.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a frame when in IDLE.
- frame_len  in  CNT_W  pixels in the frame; sampled only on accepted start.
- in_valid  in  1  upstream pixel present on the memory write buses.
- in_ready  out  1  controller accepts upstream pixel this cycle.
- out_valid  out  1  memory read outputs hold a valid pixel.
- out_ready  in  1  downstream consumes pixel this cycle.
- mem_enable  out  1  buffer enable; low clears memory read/write counters.
- mem_en_write  out  1  buffer write strobe (memory samples on posedge).
- mem_en_read  out  1  buffer read strobe (memory updates outputs on negedge).
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last pixel is consumed.
- err  out  1  one-cycle pulse when start carries illegal frame_len.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all counters=0.
  - in_ready, out_valid, mem_enable, mem_en_write, mem_en_read, busy, done, err all 0.
  - Reset mid-frame abandons the frame; the next frame starts from CLEAR.
- States: IDLE, CLEAR, FILL, DRAIN, DONE.
- IDLE: mem_enable=0.
  - start with 1 <= frame_len <= DEPTH: latch len, go CLEAR.
  - start with frame_len=0 or frame_len>DEPTH: err=1 next cycle, stay IDLE.
  - start is ignored in every other state.
- CLEAR: exactly one cycle, mem_enable=0 (memory counters zeroed); go FILL.
- FILL:
  - mem_enable=1, in_ready=1 (combinational, from state).
  - mem_en_write = in_valid & in_ready (combinational).
  - Each handshake increments wr_cnt.
  - Handshake while wr_cnt==len-1: go DRAIN, wr_cnt=0.
- DRAIN: mem_enable=1; in_ready=0.
  - fetch = !out_valid & (iss_cnt < len); mem_en_read=fetch (combinational).
  - fetch increments iss_cnt; out_valid is set on the next posedge.
  - out_valid stays high until out_ready=1, then clears; rd_cnt increments.
  - A fetch is never issued while out_valid=1, because memory outputs change at the negedge. Throughput is therefore 1 pixel per 2 cycles when out_ready is held high.
  - Consume while rd_cnt==len-1: go DONE.
- DONE: done=1 for one cycle; counters cleared; go IDLE.
- Counters: unsigned CNT_W bits; no wrap is possible because len<=DEPTH.
- Latencies:
  - CLEAR to first in_ready: 1 cycle.
  - DRAIN entry to first out_valid: 1 cycle.
  - Last consume to done: 1 cycle.
- Simultaneous events:
  - in_valid outside FILL: ignored, no write.
  - out_ready without out_valid: ignored.
  - Upstream stalls (in_valid=0) in FILL and downstream stalls in DRAIN are held indefinitely with no timeout.

Decomposition:
- Shared package ycbcr_pkg holds:
  - State encoding constants ST_IDLE..ST_DONE (3-bit).
  - CNT_W and DEPTH constants.
  - Pixel word width 32.
- One natural sub-module: ycbcr_drain_slot, the 1-deep fetch/out_valid tracker with iss_cnt/rd_cnt. Everything else stays flat.

Test Plan:
- Basic frame: start, frame_len=4, feed pixels Y=0x10..0x13 with in_valid held. Expect exactly 4 mem_en_write pulses, then out_valid pixels 0x10..0x13 in order with out_ready=1, each 2 cycles apart, then done pulse, busy=0.
- Illegal length: start with frame_len=0, then frame_len=DEPTH+1. Expect an err pulse each time, busy stays 0, no mem_en_* activity.
- Backpressure: frame_len=3, randomly drop in_valid during FILL and hold out_ready=0 for 5 cycles on pixel 2. Expect no extra writes/reads, out_valid held, data stable at 0x21, order preserved.
- Reset mid-DRAIN: assert rst_n=0 after 2 of 6 pixels consumed. Expect all outputs 0 immediately. A new start with frame_len=2 yields a CLEAR cycle (mem_enable=0) and a correct 2-pixel frame.
- Start during busy: pulse start in FILL with frame_len=9. Expect it ignored; the original len=5 frame completes with one done.
- Boundary: frame_len=1. Expect a single write, single read, done 1 cycle after consume, then IDLE.

Source files
------------

// File: rtl/ycbcr_pkg.sv
// Shared constants and state encoding for the Y/Cb/Cr frame buffer controller.
package ycbcr_pkg;

  localparam int CNT_W = 21;
  localparam int DEPTH = 1048576;
  localparam int PIX_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FILL  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/ycbcr_drain_slot.sv
// One-deep read slot: issues buffer reads and holds out_valid until consumed.
module ycbcr_drain_slot #(
  parameter int CNT_W = ycbcr_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             active,
  input  logic [CNT_W-1:0] len,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             fetch,
  output logic             last_consume
);

  logic [CNT_W-1:0] iss_cnt_q, iss_cnt_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             consume;

  // The memory updates its outputs on the negedge, so a new read may only be
  // issued once the held pixel has been consumed.
  always_comb begin
    fetch        = active & ~out_valid_q & (iss_cnt_q < len);
    consume      = active & out_valid_q & out_ready;
    last_consume = consume & (rd_cnt_q == len - CNT_W'(1));
    iss_cnt_d    = iss_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    out_valid_d  = out_valid_q;
    if (!active) begin
      iss_cnt_d   = '0;
      rd_cnt_d    = '0;
      out_valid_d = 1'b0;
    end else if (fetch) begin
      iss_cnt_d   = iss_cnt_q + CNT_W'(1);
      out_valid_d = 1'b1;
    end else if (consume) begin
      rd_cnt_d    = rd_cnt_q + CNT_W'(1);
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_cnt_q   <= '0;
      rd_cnt_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      iss_cnt_q   <= iss_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;

endmodule

// File: rtl/ycbcr_frame_ctrl.sv
// Frame sequencer for the pixel buffer: clear, fill from conversion, drain to compression.
module ycbcr_frame_ctrl import ycbcr_pkg::*; #(
  parameter int CNT_W = ycbcr_pkg::CNT_W,
  parameter int DEPTH = ycbcr_pkg::DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] frame_len,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             mem_enable,
  output logic             mem_en_write,
  output logic             mem_en_read,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [CNT_W-1:0] MaxLen = CNT_W'(DEPTH);

  state_e           state_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] wr_cnt_q;
  logic             err_q;

  logic             wr_hs;
  logic             len_ok;
  logic             drain_active;
  logic             fetch;
  logic             last_consume;

  assign in_ready     = (state_q == ST_FILL);
  assign wr_hs        = in_valid & in_ready;
  assign mem_en_write = wr_hs;
  assign mem_enable   = (state_q == ST_FILL) | (state_q == ST_DRAIN);
  assign mem_en_read  = fetch;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign err          = err_q;
  assign drain_active = (state_q == ST_DRAIN);
  assign len_ok       = (frame_len != '0) && (frame_len <= MaxLen);

  ycbcr_drain_slot #(
    .CNT_W(CNT_W)
  ) u_drain_slot (
    .clk         (clk),
    .rst_n       (rst_n),
    .active      (drain_active),
    .len         (len_q),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .fetch       (fetch),
    .last_consume(last_consume)
  );

  // mem_enable is low in IDLE and CLEAR, which zeroes the buffer's own pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      wr_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (len_ok) begin
              len_q   <= frame_len;
              state_q <= ST_CLEAR;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          wr_cnt_q <= '0;
          state_q  <= ST_FILL;
        end
        ST_FILL: begin
          if (wr_hs) begin
            if (wr_cnt_q == len_q - CNT_W'(1)) begin
              wr_cnt_q <= '0;
              state_q  <= ST_DRAIN;
            end else begin
              wr_cnt_q <= wr_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (last_consume) state_q <= ST_DONE;
        end
        ST_DONE: begin
          wr_cnt_q <= '0;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ycbcr_frame_ctrl.sv
// Directed bench for ycbcr_frame_ctrl with a small behavioural model of the pixel buffer.
module tb_ycbcr_frame_ctrl;

  localparam int CW = 21;
  localparam int DP = 1048576;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] frame_len = '0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready, out_valid, mem_enable, mem_en_write, mem_en_read;
  logic          busy, done, err;
  logic [7:0]    outVec;

  logic [31:0]   wdata = 32'h0;
  logic [31:0]   rdata = 32'h0;
  logic [31:0]   mem [0:15];
  logic [3:0]    wp = 4'd0;
  logic [3:0]    rp = 4'd0;

  int writes = 0;
  int reads = 0;
  int dones = 0;
  int errs = 0;
  int evaluated = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ycbcr_frame_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .frame_len   (frame_len),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .mem_enable  (mem_enable),
    .mem_en_write(mem_en_write),
    .mem_en_read (mem_en_read),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  assign outVec = {in_ready, out_valid, mem_enable, mem_en_write, mem_en_read, busy, done, err};

  // Buffer model: writes sampled on posedge, read outputs updated on negedge,
  // pointers cleared whenever the buffer is disabled.
  always @(posedge clk) begin
    if (!mem_enable) wp <= 4'd0;
    else if (mem_en_write) begin
      mem[wp] <= wdata;
      wp      <= wp + 4'd1;
    end
    if (mem_en_write) writes <= writes + 1;
    if (done) dones <= dones + 1;
    if (err) errs <= errs + 1;
  end

  always @(negedge clk) begin
    if (!mem_enable) rp <= 4'd0;
    else if (mem_en_read) begin
      rdata <= mem[rp];
      rp    <= rp + 4'd1;
    end
    if (mem_en_read) reads <= reads + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    evaluated++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic [CW-1:0] len, input logic iv, input logic ordy);
    start     = st;
    frame_len = len;
    in_valid  = iv;
    out_ready = ordy;
  endtask

  task automatic fillPixels(input string tag, input int n, input logic [31:0] base, input logic [15:0] dropMask);
    int idx = 0;
    int cyc = 0;
    while (idx < n && cyc < 40) begin
      if (dropMask[cyc % 16]) in_valid = 1'b0;
      else begin
        in_valid = 1'b1;
        wdata    = base + 32'(idx);
      end
      if (in_valid && in_ready) idx++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    checkOutput({tag, " fill count"}, 32'(idx), 32'(n));
  endtask

  task automatic expectPixel(input string tag, input logic [31:0] expData, output int waited);
    int k = 0;
    while (!out_valid && k < 10) begin
      tick();
      k++;
    end
    waited = k;
    checkOutput({tag, " valid"}, {31'h0, out_valid}, 32'h1);
    checkOutput({tag, " data"}, rdata, expData);
    tick();
  endtask

  task automatic finishFrame(input string tag);
    checkOutput({tag, " done pulse"}, {24'h0, outVec}, 32'h06);
    tick();
    checkOutput({tag, " idle after done"}, {24'h0, outVec}, 32'h00);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int w0, r0, d0, e0, k;

    // reset state
    #1;
    checkOutput("reset outputs", {24'h0, outVec}, 32'h00);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("idle after reset", {24'h0, outVec}, 32'h00);

    // basic frame of 4 pixels
    w0 = writes; r0 = reads;
    applyStimulus(1'b1, 21'd4, 1'b0, 1'b1);
    tick();
    checkOutput("basic clear", {24'h0, outVec}, 32'h04);
    applyStimulus(1'b0, 21'd4, 1'b0, 1'b1);
    tick();
    checkOutput("basic fill entry", {24'h0, outVec}, 32'hA4);
    fillPixels("basic", 4, 32'h10, 16'h0000);
    checkOutput("basic drain entry", {24'h0, outVec}, 32'h2C);
    for (int i = 0; i < 4; i++) begin
      expectPixel("basic pixel", 32'h10 + 32'(i), k);
      checkOutput("basic pixel spacing", 32'(k), 32'd1);
    end
    finishFrame("basic");
    checkOutput("basic writes", 32'(writes - w0), 32'd4);
    checkOutput("basic reads", 32'(reads - r0), 32'd4);

    // illegal lengths
    w0 = writes; r0 = reads; e0 = errs;
    applyStimulus(1'b1, 21'd0, 1'b0, 1'b0);
    tick();
    checkOutput("illegal zero err", {24'h0, outVec}, 32'h01);
    applyStimulus(1'b0, 21'd0, 1'b0, 1'b0);
    tick();
    checkOutput("illegal zero after", {24'h0, outVec}, 32'h00);
    applyStimulus(1'b1, 21'(DP + 1), 1'b0, 1'b0);
    tick();
    checkOutput("illegal over err", {24'h0, outVec}, 32'h01);
    applyStimulus(1'b0, 21'd0, 1'b0, 1'b0);
    tick();
    checkOutput("illegal over after", {24'h0, outVec}, 32'h00);
    checkOutput("illegal err count", 32'(errs - e0), 32'd2);
    checkOutput("illegal no mem activity", 32'((writes - w0) + (reads - r0)), 32'd0);

    // backpressure on both sides
    w0 = writes; r0 = reads;
    applyStimulus(1'b1, 21'd3, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 21'd3, 1'b0, 1'b1);
    tick();
    fillPixels("bp", 3, 32'h20, 16'h0025);
    checkOutput("bp writes", 32'(writes - w0), 32'd3);
    expectPixel("bp pixel0", 32'h20, k);
    out_ready = 1'b0;
    expectPixel("bp pixel1 held", 32'h21, k);
    for (int j = 0; j < 4; j++) begin
      checkOutput("bp hold valid", {31'h0, out_valid}, 32'h1);
      checkOutput("bp hold data", rdata, 32'h21);
      tick();
    end
    checkOutput("bp reads while held", 32'(reads - r0), 32'd2);
    out_ready = 1'b1;
    expectPixel("bp pixel1", 32'h21, k);
    expectPixel("bp pixel2", 32'h22, k);
    finishFrame("bp");
    checkOutput("bp reads", 32'(reads - r0), 32'd3);

    // reset in the middle of the drain
    applyStimulus(1'b1, 21'd6, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 21'd6, 1'b0, 1'b1);
    tick();
    fillPixels("rst", 6, 32'h30, 16'h0000);
    expectPixel("rst pixel0", 32'h30, k);
    expectPixel("rst pixel1", 32'h31, k);
    rst_n = 1'b0;
    #1;
    checkOutput("rst outputs cleared", {24'h0, outVec}, 32'h00);
    tick();
    rst_n = 1'b1;
    tick();
    w0 = writes; r0 = reads;
    applyStimulus(1'b1, 21'd2, 1'b0, 1'b1);
    tick();
    checkOutput("rst new clear", {24'h0, outVec}, 32'h04);
    applyStimulus(1'b0, 21'd2, 1'b0, 1'b1);
    tick();
    fillPixels("rst2", 2, 32'h40, 16'h0000);
    expectPixel("rst2 pixel0", 32'h40, k);
    expectPixel("rst2 pixel1", 32'h41, k);
    finishFrame("rst2");
    checkOutput("rst2 writes", 32'(writes - w0), 32'd2);

    // start pulsed while busy is ignored
    w0 = writes; d0 = dones; e0 = errs;
    applyStimulus(1'b1, 21'd5, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 21'd5, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 21'd9, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 21'd0, 1'b0, 1'b1);
    checkOutput("busy start ignored", {24'h0, outVec}, 32'hA4);
    fillPixels("busy", 5, 32'h50, 16'h0000);
    for (int i = 0; i < 5; i++) expectPixel("busy pixel", 32'h50 + 32'(i), k);
    finishFrame("busy");
    checkOutput("busy writes", 32'(writes - w0), 32'd5);
    checkOutput("busy one done", 32'(dones - d0), 32'd1);
    checkOutput("busy no err", 32'(errs - e0), 32'd0);

    // single-pixel frame
    w0 = writes; r0 = reads;
    applyStimulus(1'b1, 21'd1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 21'd1, 1'b0, 1'b1);
    tick();
    fillPixels("one", 1, 32'h60, 16'h0000);
    expectPixel("one pixel", 32'h60, k);
    checkOutput("one first latency", 32'(k), 32'd1);
    finishFrame("one");
    checkOutput("one writes", 32'(writes - w0), 32'd1);
    checkOutput("one reads", 32'(reads - r0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
    $finish;
  end

endmodule
